// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between one bridge select line and one completer.
// Latency: none, wires only.
// Backpressure: completer stretches transfers through pready.
interface apb_slave_regfile_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer: 15 R/W registers plus a read-only completed-write counter.
// Latency: setup + WAIT_STATES stalled access cycles + 1 ready cycle.
// Backpressure: pready held low for WAIT_STATES access cycles; dropping psel aborts.
module apb_slave_regfile #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input logic               hclk,
  input logic               hresetn,
  apb_slave_regfile_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  localparam logic [3:0] WS_LOAD = WAIT_STATES[3:0];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] regs_q [15];
  logic [31:0] regs_d [15];
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;

  logic        setup_err;
  logic [31:0] setup_rd;
  logic [31:0] held_rd;

  // Register-map read mux; index 15 is the write counter.
  function automatic logic [31:0] read_word(input logic [3:0] idx,
                                            input logic [31:0] wcnt);
    logic [31:0] v;
    v = wcnt;
    for (int i = 0; i < 15; i++) begin
      if (idx == 4'(i)) v = regs_q[i];
    end
    return v;
  endfunction

  // Decode of the live setup-phase address, used only on the setup edge.
  always_comb begin
    setup_err = (bus.paddr[31:6] != ADDR_BASE[31:6]) ||
                (bus.paddr[1:0] != 2'b00) ||
                (bus.pwrite && (bus.paddr[5:2] == 4'hF));
    setup_rd  = read_word(bus.paddr[5:2], wcnt_q);
    held_rd   = read_word(idx_q, wcnt_q);
  end

  // Next-state, capture, commit and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    regs_d    = regs_q;
    wcnt_d    = wcnt_q;
    prdata_d  = 32'h0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.psel && !bus.penable) begin
          idx_d   = bus.paddr[5:2];
          write_d = bus.pwrite;
          err_d   = setup_err;
          wdata_d = bus.pwdata;
          if (WAIT_STATES == 0) begin
            state_d   = S_ACCESS;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (setup_err || bus.pwrite) ? 32'h0 : setup_rd;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!bus.psel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = S_ACCESS;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (err_q || write_q) ? 32'h0 : held_rd;
          end
        end
      end

      S_ACCESS: begin
        if (!bus.psel) begin
          state_d = S_IDLE;
        end else if (bus.penable) begin
          // Completion edge: only clean writes touch the register state.
          if (write_q && !err_q) begin
            for (int i = 0; i < 15; i++) begin
              if (idx_q == 4'(i)) regs_d[i] = wdata_q;
            end
            wcnt_d = wcnt_q + 32'd1;
          end
          state_d = S_IDLE;
        end else begin
          pready_d  = pready_q;
          pslverr_d = pslverr_q;
          prdata_d  = prdata_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output flops; reset is asynchronous and discards any in-flight write.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= 4'd0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= 32'h0;
      regs_q    <= '{default: RESET_VAL};
      wcnt_q    <= 32'h0;
      prdata_q  <= 32'h0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      regs_q    <= regs_d;
      wcnt_q    <= wcnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench: three completers on a shared APB bus with different wait states/reset values.
// Latency: checks wait-state count of every transfer against the parameter.
// Backpressure: the bus driver holds the access phase until pready.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] RV0  = 32'h0000_0000;
  localparam logic [31:0] RV1  = 32'h0BAD_F00D;
  localparam logic [31:0] RV2  = 32'h5A5A_C3C3;

  logic clk;
  logic rst_n;
  logic [2:0]  psel_v;
  logic        penable_v;
  logic        pwrite_v;
  logic [31:0] paddr_v;
  logic [31:0] pwdata_v;

  int total;
  int bad;

  int          ws_of [3];
  logic [31:0] rv_of [3];
  logic [31:0] m_regs [3][15];
  logic [31:0] m_wcnt [3];

  logic        pready_w  [3];
  logic        pslverr_w [3];
  logic [31:0] prdata_w  [3];

  apb_slave_regfile_if bus0 ();
  apb_slave_regfile_if bus1 ();
  apb_slave_regfile_if bus2 ();

  assign bus0.psel = psel_v[0];
  assign bus1.psel = psel_v[1];
  assign bus2.psel = psel_v[2];
  assign bus0.penable = penable_v;
  assign bus1.penable = penable_v;
  assign bus2.penable = penable_v;
  assign bus0.pwrite = pwrite_v;
  assign bus1.pwrite = pwrite_v;
  assign bus2.pwrite = pwrite_v;
  assign bus0.paddr = paddr_v;
  assign bus1.paddr = paddr_v;
  assign bus2.paddr = paddr_v;
  assign bus0.pwdata = pwdata_v;
  assign bus1.pwdata = pwdata_v;
  assign bus2.pwdata = pwdata_v;

  assign pready_w[0]  = bus0.pready;
  assign pready_w[1]  = bus1.pready;
  assign pready_w[2]  = bus2.pready;
  assign pslverr_w[0] = bus0.pslverr;
  assign pslverr_w[1] = bus1.pslverr;
  assign pslverr_w[2] = bus2.pslverr;
  assign prdata_w[0]  = bus0.prdata;
  assign prdata_w[1]  = bus1.prdata;
  assign prdata_w[2]  = bus2.prdata;

  apb_slave_regfile #(.ADDR_BASE(BASE), .WAIT_STATES(0), .RESET_VAL(RV0)) dut0 (
    .hclk(clk), .hresetn(rst_n), .bus(bus0));
  apb_slave_regfile #(.ADDR_BASE(BASE), .WAIT_STATES(3), .RESET_VAL(RV1)) dut1 (
    .hclk(clk), .hresetn(rst_n), .bus(bus1));
  apb_slave_regfile #(.ADDR_BASE(BASE), .WAIT_STATES(2), .RESET_VAL(RV2)) dut2 (
    .hclk(clk), .hresetn(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_wcnt[d] = 32'h0;
      for (int i = 0; i < 15; i++) m_regs[d][i] = rv_of[d];
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_pready%0d", tag, d), 32'(pready_w[d]), 32'h0);
      chk($sformatf("%s_pslverr%0d", tag, d), 32'(pslverr_w[d]), 32'h0);
      chk($sformatf("%s_prdata%0d", tag, d), prdata_w[d], 32'h0);
    end
  endtask

  // Drives one full APB transfer; entered and left #1 after a rising edge.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int waits);
    psel_v    = 3'b001 << d;
    penable_v = 1'b0;
    pwrite_v  = wr;
    paddr_v   = addr;
    pwdata_v  = wdata;
    @(posedge clk); #1;
    penable_v = 1'b1;
    waits = 0;
    rdata = 32'h0;
    err   = 1'b0;
    forever begin
      @(negedge clk);
      if (pready_w[d]) begin
        rdata = prdata_w[d];
        err   = pslverr_w[d];
        break;
      end
      waits++;
      if (waits > 40) begin
        chk("timeout_pready", 32'(pready_w[d]), 32'h1);
        break;
      end
    end
    @(posedge clk); #1;
    psel_v    = 3'b000;
    penable_v = 1'b0;
  endtask

  // One transfer checked against the reference model, which is then updated.
  task automatic check_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input string tag);
    logic [3:0]  idx;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] rd;
    logic        err;
    int          waits;
    idx     = addr[5:2];
    exp_err = (addr[31:6] != BASE[31:6]) || (addr[1:0] != 2'b00) || (wr && idx == 4'hF);
    if (exp_err || wr) exp_rd = 32'h0;
    else if (idx == 4'hF) exp_rd = m_wcnt[d];
    else exp_rd = m_regs[d][idx];
    xfer(d, wr, addr, wdata, rd, err, waits);
    chk({tag, "_waits"}, 32'(waits), 32'(ws_of[d]));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_rdata"}, rd, exp_rd);
    if (wr && !exp_err) begin
      m_regs[d][idx] = wdata;
      m_wcnt[d]      = m_wcnt[d] + 32'd1;
    end
  endtask

  initial begin
    logic [3:0]  ridx;
    logic [31:0] raddr;
    int          kind;
    int          rd_dut;
    logic        rwr;

    total = 0;
    bad   = 0;
    ws_of = '{0, 3, 2};
    rv_of = '{RV0, RV1, RV2};
    psel_v = 3'b000; penable_v = 1'b0; pwrite_v = 1'b0;
    paddr_v = 32'h0; pwdata_v = 32'h0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write/read and counter readback.
    check_xfer(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, "wr0");
    check_xfer(0, 1'b0, 32'h8000_0004, 32'h0, "rd0");
    @(negedge clk);
    chk("drop_after_done", 32'(pready_w[0]), 32'h0);
    @(posedge clk); #1;
    check_xfer(0, 1'b0, 32'h8000_003C, 32'h0, "wcnt0");
    chk("wcnt0_model", m_wcnt[0], 32'h1);

    // Three wait states.
    check_xfer(1, 1'b1, 32'h8000_0008, 32'h1234_5678, "wr1");
    check_xfer(1, 1'b0, 32'h8000_0008, 32'h0, "rd1");
    @(negedge clk);
    chk("drop_after_ws3", 32'(pready_w[1]), 32'h0);
    @(posedge clk); #1;
    check_xfer(1, 1'b0, 32'h8000_0010, 32'h0, "rd1_reset_val");

    // Error transfers leave all state untouched.
    check_xfer(0, 1'b1, 32'h8000_0040, 32'h1111_1111, "err_window");
    check_xfer(0, 1'b1, 32'h8000_0002, 32'h2222_2222, "err_misalign");
    check_xfer(0, 1'b1, 32'h8000_003C, 32'h3333_3333, "err_wcnt");
    check_xfer(0, 1'b0, 32'h7FFF_FFC4, 32'h0, "err_rd_window");
    check_xfer(0, 1'b0, 32'h8000_0004, 32'h0, "after_err_reg1");
    check_xfer(0, 1'b0, 32'h8000_0000, 32'h0, "after_err_reg0");
    check_xfer(0, 1'b0, 32'h8000_003C, 32'h0, "after_err_wcnt");

    // Counter wrap from all-ones.
    force dut0.wcnt_q = 32'hFFFF_FFFF;
    #1;
    release dut0.wcnt_q;
    m_wcnt[0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check_xfer(0, 1'b0, 32'h8000_003C, 32'h0, "wcnt_preload");
    check_xfer(0, 1'b1, 32'h8000_0014, 32'hCAFE_0001, "wrap_wr");
    check_xfer(0, 1'b0, 32'h8000_003C, 32'h0, "wcnt_wrapped");

    // Abort: psel dropped in the second access cycle of a WS=2 write.
    psel_v = 3'b100; penable_v = 1'b0; pwrite_v = 1'b1;
    paddr_v = 32'h8000_000C; pwdata_v = 32'hAAAA_5555;
    @(posedge clk); #1;
    penable_v = 1'b1;
    @(posedge clk); #1;
    psel_v = 3'b000; penable_v = 1'b0;
    @(negedge clk);
    chk("abort_pready_a", 32'(pready_w[2]), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_pready_b", 32'(pready_w[2]), 32'h0);
    @(posedge clk); #1;
    check_xfer(2, 1'b0, 32'h8000_000C, 32'h0, "abort_reg3");
    check_xfer(2, 1'b0, 32'h8000_003C, 32'h0, "abort_wcnt");

    // Randomized traffic with idle gaps and stray penable pulses.
    for (int n = 0; n < 250; n++) begin
      rd_dut = $urandom_range(0, 2);
      rwr    = 1'($urandom_range(0, 1));
      kind   = $urandom_range(0, 9);
      ridx   = 4'($urandom_range(0, 15));
      raddr  = BASE | (32'(ridx) << 2);
      if (kind == 0) raddr = raddr | 32'($urandom_range(1, 3));
      if (kind == 1) raddr = raddr ^ (32'($urandom_range(1, 1023)) << 6);
      check_xfer(rd_dut, rwr, raddr, $urandom, $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) begin
        penable_v = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      penable_v = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      check_xfer(1, 1'b0, BASE | (32'(i) << 2), 32'h0, $sformatf("sweep%0d", i));
    end

    // Asynchronous reset while a read is presenting data.
    check_xfer(0, 1'b1, 32'h8000_0000, 32'h600D_F00D, "pre_rst_wr");
    psel_v = 3'b001; penable_v = 1'b0; pwrite_v = 1'b0;
    paddr_v = 32'h8000_0000;
    @(posedge clk); #1;
    penable_v = 1'b1;
    @(negedge clk);
    chk("pre_rst_pready", 32'(pready_w[0]), 32'h1);
    chk("pre_rst_prdata", prdata_w[0], 32'h600D_F00D);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pready", 32'(pready_w[0]), 32'h0);
    chk("arst_prdata", prdata_w[0], 32'h0);
    model_reset();
    @(posedge clk); #1;
    psel_v = 3'b000; penable_v = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-WAIT of a write to index 1.
    check_xfer(2, 1'b1, 32'h8000_0004, 32'h1111_2222, "pre_wait_wr");
    psel_v = 3'b100; penable_v = 1'b0; pwrite_v = 1'b1;
    paddr_v = 32'h8000_0004; pwdata_v = 32'h7777_7777;
    @(posedge clk); #1;
    penable_v = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wait_rst_pready", 32'(pready_w[2]), 32'h0);
    chk("wait_rst_pslverr", 32'(pslverr_w[2]), 32'h0);
    chk("wait_rst_prdata", prdata_w[2], 32'h0);
    model_reset();
    @(posedge clk); #1;
    psel_v = 3'b000; penable_v = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_xfer(2, 1'b0, 32'h8000_0004, 32'h0, "post_rst_reg1");
    chk("post_rst_reg1_model", m_regs[2][1], RV2);
    check_xfer(2, 1'b0, 32'h8000_003C, 32'h0, "post_rst_wcnt");
    check_xfer(0, 1'b0, 32'h8000_0000, 32'h0, "post_rst_dut0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) that terminates one `psel` line driven by the AHB-to-APB bridge controller. It implements a bank of 32-bit registers with programmable wait states, error response and a read-only write-transaction counter. It sits on the APB side of the bridge, one instance per select line.

## Interface

**Parameters**
- `ADDR_BASE`, default 32'h8000_0000: base of the 64-byte window. Bits [5:0] must be zero.
- `WAIT_STATES`, default 0: extra access cycles before `pready`. Legal range 0..15.
- `RESET_VAL`, default 32'h0: reset value of registers 0..14.

**Ports**
- `hclk`, input, 1: sole clock, rising edge.
- `hresetn`, input, 1: reset, asynchronous assert, active-low. Release is synchronous to `hclk` by the integrator.
- `psel`, input, 1: select, tied to one bit of the bridge's `psel[2:0]`.
- `penable`, input, 1: access-phase indicator.
- `pwrite`, input, 1: 1 = write, 0 = read.
- `paddr`, input, 32: byte address.
- `pwdata`, input, 32: write data.
- `prdata`, output, 32: read data. Valid only while `pready`=1 on a read, 0 otherwise.
- `pready`, output, 1: transfer completes at the edge where `psel`&`penable`&`pready`=1.
- `pslverr`, output, 1: error flag. Meaningful only while `pready`=1.

## Operation
- Register map uses word index `idx = paddr[5:2]`.
  - Indices 0..14: read/write registers.
  - Index 15: read-only counter `WCNT`, 32 bits. It increments by 1 on every completed, error-free write and wraps from FFFF_FFFF to 0.
- Error conditions, any of which makes the transfer an error transfer:
  - `paddr[31:6] != ADDR_BASE[31:6]`
  - `paddr[1:0] != 0`
  - a write to idx 15
- An error transfer completes with `pslverr`=1 and `prdata`=0. No register or `WCNT` changes.
- State machine, registered with states IDLE, WAIT, ACCESS:
  - **IDLE**
    - `psel`=1, `penable`=0 (setup): capture `paddr`/`pwrite`/`pwdata` and evaluate the error condition.
      - If `WAIT_STATES`=0, go to ACCESS.
      - Otherwise load the wait counter with `WAIT_STATES` and go to WAIT.
    - Anything else: stay in IDLE.
  - **WAIT**
    - `psel`=0: go to IDLE (abort, no commit).
    - Otherwise decrement the counter. When it reaches 0, go to ACCESS.
  - **ACCESS**
    - `pready`=1. On the edge where `psel`&`penable`=1, commit the write (data to register, `WCNT`+1) and go to IDLE.
    - `psel`=0: go to IDLE with no commit.
- Read data comes from the captured address. The capture is taken at the setup edge, so `paddr` changes during the access phase are ignored.
- A same-cycle write to register k and read of k cannot occur, because APB serialises transfers.

## Timing
- All outputs are registered.
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, registers 0..14 = `RESET_VAL`, `WCNT`=0, state IDLE.
- Assertion of `hresetn`=0 mid-transfer forces reset values immediately (asynchronous), and the in-flight write is discarded.
- Zero wait states: setup in cycle T, access in T+1 with `pready`=1. Commit happens at the end of T+1. This is compatible with the bridge, which does not sample `pready`.
- N wait states: `pready` is low for access cycles T+1..T+N and high in T+N+1.
- `pready`, `pslverr` and `prdata` drop to 0 in the cycle after completion.
- Back-to-back transfers: a new setup in the cycle after completion is accepted with no idle cycle required.
- `penable`=1 while in IDLE, with no setup seen, is ignored.

## Test plan
- Reset, then zero-wait write of DEAD_BEEF to 8000_0004, then read of 8000_0004:
  - Write: `pready`=1 in the access cycle, `pslverr`=0.
  - Read: `prdata`=DEAD_BEEF, `WCNT` read at 8000_003C = 1.
- `WAIT_STATES`=3, read of 8000_0008 after writing 1234_5678:
  - `pready` low for exactly 3 access cycles, then high for 1.
  - `prdata`=1234_5678.
- Error cases:
  - Write to 8000_0040 (out of window): `pslverr`=1.
  - Write to 8000_0002 (misaligned): `pslverr`=1.
  - Write to 8000_003C (counter): `pslverr`=1.
  - After all three: registers unchanged and `WCNT` still unchanged.
- `WCNT` wrap: preload via 2^32-1 writes (or force), one more write → `WCNT`=0.
- Abort: `WAIT_STATES`=2, `psel` dropped in the second access cycle of a write of AAAA_5555 to idx 3 → register 3 keeps its old value, FSM is in IDLE, `pready`=0.
- Asynchronous reset: assert `hresetn` mid-WAIT during a write to idx 1 → `pready`/`pslverr`/`prdata` go to 0 without a clock edge, register 1 = `RESET_VAL`, `WCNT`=0.
